// File: rtl/alu_writeback_if.sv
// Result-commit bus between the ALU/control side (master) and the write-back stage (slave).
// Handshake: a result transfers on a rising edge where iValid && oReady; the master holds all inputs until then.
interface alu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              iValid;
  logic              oReady;
  logic [3:0]        iCtrl;
  logic [DATA_W-1:0] iC_hi;
  logic [DATA_W-1:0] iC_lo;
  logic              iZero;
  logic              iNeg;
  logic [REG_AW-1:0] iDst;
  logic              iStall;
  logic              oRfWe;
  logic [REG_AW-1:0] oRfAddr;
  logic [DATA_W-1:0] oRfData;
  logic              oLoWe;
  logic [DATA_W-1:0] oLoData;
  logic              oHiWe;
  logic [DATA_W-1:0] oHiData;
  logic              oZeroFlag;
  logic              oNegFlag;
  logic              oBusy;
  logic              oDone;
  logic [6:0]        oDbg;     // {latched ctrl, fsm state}

  modport master (
    output iValid, iCtrl, iC_hi, iC_lo, iZero, iNeg, iDst, iStall,
    input  oReady, oRfWe, oRfAddr, oRfData, oLoWe, oLoData, oHiWe, oHiData,
           oZeroFlag, oNegFlag, oBusy, oDone, oDbg
  );

  modport slave (
    input  iValid, iCtrl, iC_hi, iC_lo, iZero, iNeg, iDst, iStall,
    output oReady, oRfWe, oRfAddr, oRfData, oLoWe, oLoData, oHiWe, oHiData,
           oZeroFlag, oNegFlag, oBusy, oDone, oDbg
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU result-commit stage: captures a result, then writes it to the register file
// or to LO/HI (MUL/DIV) and pulses done.
module alu_writeback #(
  parameter int         DATA_W       = 32,
  parameter int         REG_AW       = 4,
  parameter logic [3:0] CTRL_ALU_MUL = 4'd6,
  parameter logic [3:0] CTRL_ALU_DIV = 4'd7
) (
  input logic           iClk,
  input logic           iRst,
  alu_writeback_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_RF = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] z_hi;
  logic [DATA_W-1:0] z_lo;
  logic [REG_AW-1:0] dst;
  logic [3:0]        ctrl;
  logic              zero_flag;
  logic              neg_flag;
  logic              capture;
  logic              is_muldiv;

  assign capture   = (state == IDLE) && bus.iValid;
  assign is_muldiv = (bus.iCtrl == CTRL_ALU_MUL) || (bus.iCtrl == CTRL_ALU_DIV);

  // State and result registers; data only moves on a capture.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      z_hi      <= '0;
      z_lo      <= '0;
      dst       <= '0;
      ctrl      <= '0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        z_hi      <= bus.iC_hi;
        z_lo      <= bus.iC_lo;
        dst       <= bus.iDst;
        ctrl      <= bus.iCtrl;
        zero_flag <= bus.iZero;
        neg_flag  <= bus.iNeg;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.iValid) state_nxt = is_muldiv ? WR_LO : WR_RF;
      WR_RF:   if (!bus.iStall) state_nxt = DONE;
      WR_LO:   if (!bus.iStall) state_nxt = WR_HI;
      WR_HI:   if (!bus.iStall) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from state so a stall removes the write in the same cycle.
  always_comb begin
    bus.oReady = 1'b0;
    bus.oBusy  = 1'b1;
    bus.oRfWe  = 1'b0;
    bus.oLoWe  = 1'b0;
    bus.oHiWe  = 1'b0;
    bus.oDone  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.oReady = 1'b1;
        bus.oBusy  = 1'b0;
      end
      WR_RF:   bus.oRfWe = ~bus.iStall;
      WR_LO:   bus.oLoWe = ~bus.iStall;
      WR_HI:   bus.oHiWe = ~bus.iStall;
      DONE:    bus.oDone = 1'b1;
      default: ;
    endcase
  end

  assign bus.oRfAddr   = dst;
  assign bus.oRfData   = z_lo;
  assign bus.oLoData   = z_lo;
  assign bus.oHiData   = z_hi;
  assign bus.oZeroFlag = zero_flag;
  assign bus.oNegFlag  = neg_flag;
  assign bus.oDbg      = {ctrl, state};

endmodule
